char_bridge: RTL

Buffered, flow-controlled byte bridge between a UART receive AXI-Stream and the text console's single-cycle `putchar`/`clearhome` command pulses. It replaces the fixed "one byte, one pulse, hope the console is done" glue in the serial terminal top with a parametrised FIFO, a minimum-gap timer and an optional console busy handshake. Sits between `uart_pc` (m_axis side) and `control` in the serial terminal top level.

---
 rtl/serterm_pkg.sv | 16 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/char_bridge.sv | 101 ++++++++++
 3 files changed

// File: rtl/serterm_pkg.sv
// rtl/serterm_pkg.sv - shared types and console control characters for the serial terminal
package serterm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } bridge_state_t;

    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_FF  = 8'h0C;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_ESC = 8'h1B;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO with occupancy count
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [DATA_WIDTH-1:0]    i_push_data,
    input  logic                     i_pop,
    output logic [DATA_WIDTH-1:0]    o_head,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  push_ok;
    logic                  pop_ok;

    // Writes are refused while full even if a pop lands in the same cycle,
    // so the full flag only depends on the registered count.
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;

    assign o_full  = (count == FULL_LEVEL);
    assign o_empty = (count == '0);
    assign o_level = count;
    assign o_head  = mem[rd_ptr];

    // Storage array; contents are not reset and simply become stale.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally; the extra count bit separates full from empty.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/char_bridge.sv
// rtl/char_bridge.sv - buffered, paced bridge from UART rx stream to console command pulses
module char_bridge
    import serterm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 0,
    parameter int USE_BUSY   = 1,
    parameter int MAP_FF     = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic                     o_putchar,
    output logic                     o_clearhome,
    output logic [DATA_WIDTH-1:0]    o_char,
    input  logic                     i_busy,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam logic [15:0]           GAP_LOAD = 16'(GAP_CYCLES);
    localparam logic [DATA_WIDTH-1:0] FF_CHAR  = DATA_WIDTH'(ASCII_FF);

    bridge_state_t         state;
    bridge_state_t         state_n;
    logic [15:0]           gap_cnt;
    logic [15:0]           gap_n;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;

    assign s_axis_tready = !fifo_full;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (s_axis_tvalid),
        .i_push_data (s_axis_tdata),
        .i_pop       (pop),
        .o_head      (fifo_head),
        .o_level     (o_level),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

    // State, gap counter and the held character; reset aborts any command in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
            o_char  <= '0;
        end else begin
            state   <= state_n;
            gap_cnt <= gap_n;
            if (pop) begin
                o_char <= fifo_head;
            end
        end
    end

    // Pulses are decoded from state so they vanish the moment reset asserts.
    always_comb begin
        state_n     = state;
        gap_n       = gap_cnt;
        pop         = 1'b0;
        o_putchar   = 1'b0;
        o_clearhome = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if ((MAP_FF != 0) && (o_char == FF_CHAR)) begin
                    o_clearhome = 1'b1;
                end else begin
                    o_putchar = 1'b1;
                end
                gap_n   = GAP_LOAD;
                state_n = GAP;
            end
            GAP: begin
                if (gap_cnt != 16'd0) begin
                    gap_n = gap_cnt - 16'd1;
                end else if ((USE_BUSY == 0) || !i_busy) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
